// File: rtl/osc_cal_pkg.sv
// Shared types and helpers for the ring-oscillator frequency calibration block.
// Holds the controller state encoding, code field widths and the coarse thermometer map.
package osc_cal_pkg;

    localparam int CODE_W = 7;
    localparam int FINE_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        DECIDE  = 3'd3,
        HOLD    = 3'd4,
        TRACK   = 3'd5
    } cal_state_e;

    // Coarse step k lights the k lowest delay cells.
    function automatic logic [6:0] coarse2therm(input logic [2:0] k);
        return 7'((8'd1 << k) - 8'd1);
    endfunction

endpackage

// File: rtl/osc_code_map.sv
// Registers the combined delay code onto the oscillator's coarse (thermometer)
// and fine (binary) delay controls.
module osc_code_map
    import osc_cal_pkg::*;
#(
    parameter logic [CODE_W-1:0] CODE_INIT = 7'd64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code,
    output logic [6:0]        delay_con_msb,
    output logic [FINE_W-1:0] delay_con_lsb
);

    always_ff @(posedge clk) begin
        if (rst) begin
            delay_con_msb <= coarse2therm(CODE_INIT[6:4]);
            delay_con_lsb <= CODE_INIT[3:0];
        end else begin
            delay_con_msb <= coarse2therm(code[6:4]);
            delay_con_lsb <= code[3:0];
        end
    end

endmodule

// File: rtl/osc_freq_cal.sv
// Ring-oscillator frequency calibration: 7-bit SAR search of the delay code against
// a counted window of oscillator edges, followed by optional +/-1 tracking.
module osc_freq_cal
    import osc_cal_pkg::*;
#(
    parameter int                CNT_W      = 12,
    parameter int                WIN_CYC    = 256,
    parameter int                SETTLE_CYC = 16,
    parameter logic [CODE_W-1:0] CODE_INIT  = 7'd64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_req,
    input  logic              cal_start,
    input  logic              track_en,
    input  logic [CNT_W-1:0]  target_cnt,
    input  logic [3:0]        tol,
    input  logic [CNT_W-1:0]  osc_cnt,
    output logic              glob_en,
    output logic [6:0]        delay_con_msb,
    output logic [FINE_W-1:0] delay_con_lsb,
    output logic [CODE_W-1:0] code,
    output logic              busy,
    output logic              cal_done,
    output logic              locked,
    output logic              sat_err,
    output cal_state_e        state_dbg
);

    localparam int WCNT_W = $clog2((WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC);
    localparam int BW     = CNT_W + 1;
    localparam logic [CODE_W-1:0] SAR_START = 7'b1000000;
    localparam logic [CODE_W-1:0] CODE_MAX  = 7'd127;

    cal_state_e        state;
    logic [2:0]        bit_idx;
    logic [WCNT_W-1:0] win_cnt;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;
    logic              track_mode;

    logic [CNT_W-1:0]  delta;
    logic [CNT_W-1:0]  lo_band;
    logic [BW-1:0]     hi_band;
    logic              step_up;
    logic              step_dn;
    logic [CODE_W-1:0] sar_code;

    assign state_dbg = state;

    // Modular subtraction absorbs a single counter wrap inside the window.
    always_comb begin
        delta    = cnt1 - cnt0;
        hi_band  = {1'b0, target_cnt} + BW'(tol);
        lo_band  = (target_cnt >= CNT_W'(tol)) ? (target_cnt - CNT_W'(tol)) : '0;
        step_up  = {1'b0, delta} > hi_band;
        step_dn  = delta < lo_band;
        sar_code = (delta > target_cnt) ? code : (code & ~(CODE_W'(1) << bit_idx));
    end

    always_ff @(posedge clk) begin
        cal_done <= 1'b0;
        if (rst) begin
            state      <= IDLE;
            code       <= CODE_INIT;
            bit_idx    <= 3'd6;
            win_cnt    <= '0;
            cnt0       <= '0;
            cnt1       <= '0;
            track_mode <= 1'b0;
            glob_en    <= 1'b0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            sat_err    <= 1'b0;
        end else if (!en_req) begin
            state      <= IDLE;
            code       <= CODE_INIT;
            win_cnt    <= '0;
            track_mode <= 1'b0;
            glob_en    <= 1'b0;
            busy       <= 1'b0;
            locked     <= 1'b0;
        end else if (cal_start) begin
            state      <= SETTLE;
            code       <= SAR_START;
            bit_idx    <= 3'd6;
            win_cnt    <= '0;
            track_mode <= 1'b0;
            glob_en    <= 1'b1;
            busy       <= 1'b1;
            locked     <= 1'b0;
            sat_err    <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                end
                SETTLE: begin
                    if (win_cnt == WCNT_W'(SETTLE_CYC - 1)) begin
                        cnt0    <= osc_cnt;
                        win_cnt <= '0;
                        state   <= MEASURE;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (win_cnt == WCNT_W'(WIN_CYC - 1)) begin
                        cnt1    <= osc_cnt;
                        win_cnt <= '0;
                        state   <= DECIDE;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                DECIDE: begin
                    if (track_mode) begin
                        // Saturate at the code limits and flag it instead of wrapping.
                        if (step_up) begin
                            if (code == CODE_MAX) sat_err <= 1'b1;
                            else                  code    <= code + 7'd1;
                        end else if (step_dn) begin
                            if (code == '0) sat_err <= 1'b1;
                            else            code    <= code - 7'd1;
                        end
                        state <= SETTLE;
                    end else if (bit_idx != 3'd0) begin
                        code    <= sar_code | (CODE_W'(1) << (bit_idx - 3'd1));
                        bit_idx <= bit_idx - 3'd1;
                        state   <= SETTLE;
                    end else begin
                        code     <= sar_code;
                        cal_done <= 1'b1;
                        locked   <= 1'b1;
                        if (track_en) begin
                            state      <= TRACK;
                            track_mode <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            state <= HOLD;
                            busy  <= 1'b0;
                        end
                    end
                end
                TRACK: begin
                    state <= SETTLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    osc_code_map #(
        .CODE_INIT(CODE_INIT)
    ) u_code_map (
        .clk          (clk),
        .rst          (rst),
        .code         (code),
        .delay_con_msb(delay_con_msb),
        .delay_con_lsb(delay_con_lsb)
    );

endmodule
